data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Multi-cycle data-memory target serving the CPU's MEM-stage load/store requests, driven from the EX/MEM pipeline register.
- Latches one request, holds the pipeline via stall_o for a programmable latency, then completes with a one-cycle ack_o.
- Replaces the single-cycle data memory when modelling realistic memory timing.
- Word-addressed storage: DEPTH_WORDS x 32 bits.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; byte address range 0 .. 4*DEPTH_WORDS-1
LATENCY, 3, cycles from request accept to ack_o; legal range 1..15
CNT_W, 4, width of the internal latency counter; must hold LATENCY

Ports:
clk_i  input  1  clock; all state updates on its rising edge
rst_i  input  1  asynchronous, active-low reset
start_i  input  1  CPU run enable; no new request accepted while low
MemRead_i  input  1  load request from EX/MEM
MemWrite_i  input  1  store request from EX/MEM
addr_i  input  32  byte address (ALU result)
data_i  input  32  store data
data_o  output  32  load data, registered
stall_o  output  1  hold PC, IF/ID, ID/EX and EX/MEM while high
ack_o  output  1  one-cycle completion pulse
err_o  output  1  one-cycle pulse on a rejected request

Behaviour:
- Reset, while rst_i is low:
  - state=IDLE, counter=0, data_o=0, stall_o=0, ack_o=0, err_o=0.
  - Memory array is not cleared; its contents persist across reset.
  - A request in flight is aborted and a pending write is never committed.
- Valid request: start_i=1 and exactly one of MemRead_i/MemWrite_i is high.
- Error conditions, checked only in IDLE:
  - Both MemRead_i and MemWrite_i high.
  - addr_i[1:0] != 0.
  - addr_i >= 4*DEPTH_WORDS.
  - Response: err_o=1 for that cycle, stall_o=0, no access, state stays IDLE.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On a valid, error-free request: latch op, addr_i[log2(DEPTH_WORDS)+1:2] and data_i; set counter=LATENCY-1.
  - Next state is BUSY if LATENCY>1, otherwise DONE.
  - stall_o is combinationally high during the accept cycle, so EX/MEM holds at the next edge.
- BUSY:
  - stall_o=1; counter decrements each cycle.
  - When counter==1, next state is DONE.
  - Inputs are ignored; the latched request is authoritative.
- DONE:
  - stall_o=0, ack_o=1.
  - Read: data_o was loaded with mem[latched addr] on the edge entering DONE.
  - Write: mem[latched addr] <= latched data on the edge leaving DONE.
  - Next state is IDLE unconditionally; inputs are not sampled in DONE, so the same request is never re-accepted.
- Latency:
  - Accept in cycle 0; stall_o high in cycles 0..LATENCY-1; ack_o in cycle LATENCY.
  - Back-to-back accesses give a throughput of one access per LATENCY+1 cycles.
- data_o holds its last load value through writes, errors and idle cycles.
- start_i falling mid-operation: the in-flight access completes normally; no new accept until start_i returns high.
- Read-after-write to the same address: the read accepted in the IDLE cycle after the write's DONE returns the new data.
- Simultaneous rst_i low and any request: reset wins.

Test Plan:
- LATENCY=3. Write addr=0x10, data=0xDEADBEEF, then read 0x10.
  - Each access: stall_o high 3 cycles, then ack_o pulse.
  - Read gives data_o=0xDEADBEEF on the ack cycle.
- LATENCY=1. Back-to-back writes to 0x0 and 0x4 (0x11111111, 0x22222222), then reads of both.
  - stall_o is 1 cycle per access; ack_o pulses at cycles 1, 3, 5, 7.
  - Reads return 0x11111111 and 0x22222222.
- Error requests:
  - Read at 0x6 (misaligned): err_o one cycle, stall_o=0, data_o unchanged.
  - Read at 0x400 (out of range for DEPTH_WORDS=256): same response.
  - MemRead_i=MemWrite_i=1: same response.
- Reset mid-write.
  - Stimulus: write 0xCAFEF00D to 0x20 (old value 0x12345678); assert rst_i low during BUSY.
  - Required: stall_o=0 and data_o=0 immediately after reset; a subsequent read of 0x20 returns 0x12345678.
- Input change during BUSY.
  - Stimulus: accept a read of 0x8, then change addr_i to 0xC and data_i during the stall.
  - Required: data_o = mem[0x8]; no second access is started.
- start_i=0 with MemRead_i=1.
  - Required: no stall_o, no ack_o, no err_o.
  - After raising start_i: normal access with ack_o after LATENCY cycles.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle word-addressed data memory for the MEM stage: accepts one load/store,
// stalls the pipeline for LATENCY cycles, then pulses ack_o for one cycle.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3,
  parameter int CNT_W       = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam bit MULTI_CYCLE = (LATENCY > 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      mem_q [DEPTH_WORDS];

  logic             req_s;
  logic             bad_s;
  logic [AW-1:0]    idx_s;
  logic             stall_s;
  logic             err_s;

  function automatic logic addr_err(input logic [31:0] a, input logic rd, input logic wr);
    return (rd & wr) | (a[1:0] != 2'b00) | (a >= ADDR_LIMIT);
  endfunction

  assign req_s = start_i & (MemRead_i | MemWrite_i);
  assign bad_s = addr_err(addr_i, MemRead_i, MemWrite_i);
  assign idx_s = addr_i[AW+1:2];

  // Next-state, request latching and combinational stall/err decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    stall_s = 1'b0;
    err_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s && bad_s) begin
          err_s = 1'b1;
        end else if (req_s) begin
          stall_s = 1'b1;
          we_d    = MemWrite_i;
          idx_d   = idx_s;
          wdata_d = data_i;
          cnt_d   = CNT_INIT;
          if (MULTI_CYCLE) begin
            state_d = BUSY;
          end else begin
            state_d = DONE;
            if (!MemWrite_i) begin
              rdata_d = mem_q[idx_s];
            end else begin
              rdata_d = rdata_q;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        stall_s = 1'b1;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          if (!we_q) begin
            rdata_d = mem_q[idx_q];
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and datapath registers; the in-flight request is dropped on reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is not reset; the store commits on the edge leaving DONE.
  always_ff @(posedge clk_i) begin
    if (state_q == DONE && we_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign data_o  = rdata_q;
  assign ack_o   = (state_q == DONE);
  assign stall_o = stall_s & rst_i;
  assign err_o   = err_s & rst_i;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=3 and a LATENCY=1 instance checked
// against a transaction-level memory model with directed and random accesses.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, rd, wr;
  logic [31:0] addr, wdata;
  bit          sel;

  logic [31:0] do3, do1;
  logic        stall3, ack3, err3, stall1, ack1, err1;
  logic        start3, start1;
  logic [31:0] dout;
  logic        stall, ack, err;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  logic [31:0] mdl     [2][256];
  bit          vld     [2][256];
  logic [31:0] last_ld [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign start3 = start & ~sel;
  assign start1 = start & sel;
  assign dout   = sel ? do1 : do3;
  assign stall  = sel ? stall1 : stall3;
  assign ack    = sel ? ack1 : ack3;
  assign err    = sel ? err1 : err3;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3), .CNT_W(4)) u_dut3 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start3), .MemRead_i(rd), .MemWrite_i(wr),
    .addr_i(addr), .data_i(wdata), .data_o(do3), .stall_o(stall3), .ack_o(ack3), .err_o(err3)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1), .CNT_W(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start1), .MemRead_i(rd), .MemWrite_i(wr),
    .addr_i(addr), .data_i(wdata), .data_o(do1), .stall_o(stall1), .ack_o(ack1), .err_o(err1)
  );

  // One complete access on the selected instance; model updated at completion.
  task automatic do_access(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                           output int acc_cyc, output int ack_cyc);
    int lat;
    int idx;
    lat = sel ? 1 : 3;
    idx = int'(a[9:2]);
    @(posedge clk); #1;
    start = 1'b1; rd = !is_wr; wr = is_wr; addr = a; wdata = d;
    acc_cyc = cyc;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1 || ack !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL accept sel=%0d a=%h: stall=%b ack=%b err=%b, required 1 0 0", sel, a, stall, ack, err);
    end
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      rd = 1'b0; wr = 1'b0;
      @(negedge clk);
      n_checks++;
      if (c < lat) begin
        if (stall !== 1'b1 || ack !== 1'b0) begin
          n_fail++;
          $display("FAIL busy sel=%0d c=%0d: stall=%b ack=%b, required 1 0", sel, c, stall, ack);
        end
      end else begin
        if (stall !== 1'b0 || ack !== 1'b1) begin
          n_fail++;
          $display("FAIL done sel=%0d: stall=%b ack=%b, required 0 1", sel, stall, ack);
        end
      end
    end
    ack_cyc = cyc;
    n_checks++;
    if (is_wr) begin
      if (dout !== last_ld[sel]) begin
        n_fail++;
        $display("FAIL data_hold sel=%0d: data_o=%h, required %h", sel, dout, last_ld[sel]);
      end
      mdl[sel][idx] = d;
      vld[sel][idx] = 1'b1;
    end else begin
      if (dout !== mdl[sel][idx]) begin
        n_fail++;
        $display("FAIL read sel=%0d a=%h: data_o=%h, required %h", sel, a, dout, mdl[sel][idx]);
      end
      last_ld[sel] = mdl[sel][idx];
    end
  endtask

  // A rejected request: one-cycle err_o, no stall, data_o held, no access afterwards.
  task automatic err_request(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    start = 1'b1; rd = r; wr = w; addr = a; wdata = d;
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || stall !== 1'b0 || ack !== 1'b0 || dout !== last_ld[sel]) begin
      n_fail++;
      $display("FAIL err_req a=%h rw=%b%b: err=%b stall=%b ack=%b data_o=%h, required 1 0 0 %h",
               a, r, w, err, stall, ack, dout, last_ld[sel]);
    end
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || stall !== 1'b0 || ack !== 1'b0) begin
      n_fail++;
      $display("FAIL err_after a=%h: err=%b stall=%b ack=%b, required 0 0 0", a, err, stall, ack);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0; start = 1'b1; rd = 1'b1; addr = 32'h0000_0010;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (stall3 !== 1'b0 || ack3 !== 1'b0 || err3 !== 1'b0 || do3 !== 32'h0 ||
        stall1 !== 1'b0 || ack1 !== 1'b0 || err1 !== 1'b0 || do1 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: s3=%b a3=%b e3=%b d3=%h s1=%b a1=%b e1=%b d1=%h, required all 0",
               stall3, ack3, err3, do3, stall1, ack1, err1, do1);
    end
    start = 1'b0; rd = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_ld[0] = 32'h0; last_ld[1] = 32'h0;
  endtask

  task automatic test_write_read_lat3();
    int a0, k0;
    sel = 1'b0;
    do_access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, a0, k0);
    n_checks++;
    if (k0 - a0 !== 3) begin
      n_fail++;
      $display("FAIL lat3_ack_cycle: got %0d, required 3", k0 - a0);
    end
    do_access(1'b0, 32'h0000_0010, 32'h0, a0, k0);
    n_checks++;
    if (do3 !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL lat3_read: data_o=%h, required deadbeef", do3);
    end
  endtask

  task automatic test_back_to_back();
    int acc [4];
    int ak  [4];
    logic [31:0] ad [4];
    bit          op [4];
    sel = 1'b1;
    ad[0] = 32'h0; ad[1] = 32'h4; ad[2] = 32'h0; ad[3] = 32'h4;
    op[0] = 1'b1;  op[1] = 1'b1;  op[2] = 1'b0;  op[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_access(op[i], ad[i], (i == 0) ? 32'h1111_1111 : 32'h2222_2222, acc[i], ak[i]);
      n_checks++;
      if (ak[i] - acc[0] !== 2 * i + 1) begin
        n_fail++;
        $display("FAIL b2b_ack_cycle i=%0d: got %0d, required %0d", i, ak[i] - acc[0], 2 * i + 1);
      end
    end
    n_checks++;
    if (do1 !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL b2b_last_read: data_o=%h, required 22222222", do1);
    end
  endtask

  task automatic test_errors();
    int a0, k0;
    sel = 1'b0;
    err_request(1'b1, 1'b0, 32'h0000_0006, 32'h0);
    err_request(1'b1, 1'b0, 32'h0000_0400, 32'h0);
    err_request(1'b1, 1'b1, 32'h0000_0010, 32'hBAD0_BAD0);
    err_request(1'b0, 1'b1, 32'h0000_0012, 32'hBAD0_BAD0);
    err_request(1'b0, 1'b1, 32'h0000_0410, 32'hBAD0_BAD0);
    do_access(1'b0, 32'h0000_0010, 32'h0, a0, k0);
  endtask

  task automatic test_reset_mid_write();
    int a0, k0;
    sel = 1'b0;
    do_access(1'b1, 32'h0000_0020, 32'h1234_5678, a0, k0);
    @(posedge clk); #1;
    start = 1'b1; wr = 1'b1; addr = 32'h0000_0020; wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    wr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (stall3 !== 1'b0 || ack3 !== 1'b0 || do3 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_write: stall=%b ack=%b data_o=%h, required 0 0 0", stall3, ack3, do3);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_ld[0] = 32'h0; last_ld[1] = 32'h0;
    do_access(1'b0, 32'h0000_0020, 32'h0, a0, k0);
  endtask

  task automatic test_busy_change();
    int a0, k0;
    logic [31:0] r8, rc;
    sel = 1'b0;
    r8 = $urandom; rc = $urandom;
    do_access(1'b1, 32'h0000_0008, r8, a0, k0);
    do_access(1'b1, 32'h0000_000C, rc, a0, k0);
    @(posedge clk); #1;
    start = 1'b1; rd = 1'b1; addr = 32'h0000_0008;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (c < 3) begin
        rd = 1'b0; wr = 1'b1; addr = 32'h0000_000C; wdata = $urandom;
      end else begin
        rd = 1'b0; wr = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if (stall !== (c < 3) || ack !== (c == 3)) begin
        n_fail++;
        $display("FAIL busy_change c=%0d: stall=%b ack=%b, required %b %b", c, stall, ack, c < 3, c == 3);
      end
    end
    n_checks++;
    if (dout !== r8) begin
      n_fail++;
      $display("FAIL busy_change_read: data_o=%h, required %h", dout, r8);
    end
    last_ld[0] = r8;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b0 || ack !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_change_idle: stall=%b ack=%b, required 0 0", stall, ack);
      end
    end
    do_access(1'b0, 32'h0000_000C, 32'h0, a0, k0);
  endtask

  task automatic test_start_low();
    int a0, k0;
    sel = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; rd = 1'b1; addr = 32'h0000_0008;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b0 || ack !== 1'b0 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL start_low: stall=%b ack=%b err=%b, required 0 0 0", stall, ack, err);
      end
      @(posedge clk); #1;
    end
    do_access(1'b0, 32'h0000_0008, 32'h0, a0, k0);
    n_checks++;
    if (k0 - a0 !== 3) begin
      n_fail++;
      $display("FAIL start_low_latency: got %0d, required 3", k0 - a0);
    end
  endtask

  task automatic test_random();
    int a0, k0;
    int idx;
    logic [31:0] a;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      for (int i = 0; i < 24; i++) begin
        idx = 64 + int'($urandom_range(0, 7));
        a = 32'(idx * 4);
        if ($urandom_range(0, 5) == 0) begin
          a = a | 32'($urandom_range(1, 3));
          err_request(1'b0, 1'b1, a, $urandom);
        end else if (!vld[sel][idx] || $urandom_range(0, 1) == 0) begin
          do_access(1'b1, a, $urandom, a0, k0);
        end else begin
          do_access(1'b0, a, 32'h0, a0, k0);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rd = 1'b0; wr = 1'b0;
    addr = 32'h0; wdata = 32'h0; sel = 1'b0;
    last_ld[0] = 32'h0; last_ld[1] = 32'h0;
    for (int s = 0; s < 2; s++) begin
      for (int j = 0; j < 256; j++) begin
        vld[s][j] = 1'b0;
        mdl[s][j] = 32'h0;
      end
    end
    test_reset();
    test_write_read_lat3();
    test_back_to_back();
    test_errors();
    test_reset_mid_write();
    test_busy_change();
    test_start_low();
    test_random();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
